// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port and decode-stage handshake of the fetch sequencer.
// master = sequencer side; slave = memory/decoder side.
interface fetch_sequencer_if #(
   parameter int PC_W = 5
);
   logic            imem_rd_en;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_data;
   logic            dec_valid;
   logic            dec_ready;
   logic [31:0]     dec_instr;
   logic [PC_W-1:0] dec_pc;
   logic            branch_valid;
   logic [PC_W-1:0] branch_target;

   modport master (
      output imem_rd_en,
      output imem_addr,
      input  imem_data,
      output dec_valid,
      input  dec_ready,
      output dec_instr,
      output dec_pc,
      input  branch_valid,
      input  branch_target
   );

   modport slave (
      input  imem_rd_en,
      input  imem_addr,
      output imem_data,
      input  dec_valid,
      output dec_ready,
      input  dec_instr,
      input  dec_pc,
      output branch_valid,
      output branch_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks the PC over instruction memory with one read
// outstanding at a time and hands each fetched word to decode over valid/ready.
module fetch_sequencer #(
   parameter int PC_W     = 5,
   parameter int PROG_LEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              halt_req,
   output logic              busy,
   output logic              done,
   output logic [7:0]        fetch_count,
   fetch_sequencer_if.master bus
);
   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
   localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_ISSUE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_r;
   logic [PC_W-1:0] pc_r;
   logic            imem_rd_en_r;
   logic [PC_W-1:0] imem_addr_r;
   logic            dec_valid_r;
   logic [31:0]     dec_instr_r;
   logic [PC_W-1:0] dec_pc_r;
   logic            busy_r;
   logic            done_r;
   logic [7:0]      fetch_count_r;

   logic            xfer_s;
   logic            stop_s;
   logic [PC_W-1:0] next_pc_s;
   logic [7:0]      count_inc_s;

   assign bus.imem_rd_en = imem_rd_en_r;
   assign bus.imem_addr  = imem_addr_r;
   assign bus.dec_valid  = dec_valid_r;
   assign bus.dec_instr  = dec_instr_r;
   assign bus.dec_pc     = dec_pc_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign fetch_count    = fetch_count_r;

   // Transfer detection and the follow-on decision for the instruction being accepted.
   always_comb begin
      xfer_s      = 1'b0;
      stop_s      = 1'b0;
      next_pc_s   = dec_pc_r + PC_ONE;
      count_inc_s = fetch_count_r;
      if (state_r == S_ISSUE) begin
         xfer_s = bus.dec_ready;
      end else begin
         xfer_s = 1'b0;
      end
      // Halt overrides a branch; a branch overrides end-of-program.
      if (halt_req) begin
         stop_s = 1'b1;
      end else if (bus.branch_valid) begin
         stop_s    = 1'b0;
         next_pc_s = bus.branch_target;
      end else begin
         stop_s = (dec_pc_r == LAST_PC);
      end
      if (fetch_count_r != 8'd255) begin
         count_inc_s = fetch_count_r + 8'd1;
      end else begin
         count_inc_s = fetch_count_r;
      end
   end

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= S_IDLE;
         pc_r          <= '0;
         imem_rd_en_r  <= 1'b0;
         imem_addr_r   <= '0;
         dec_valid_r   <= 1'b0;
         dec_instr_r   <= 32'd0;
         dec_pc_r      <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         fetch_count_r <= 8'd0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_r       <= S_FETCH;
                  pc_r          <= '0;
                  imem_rd_en_r  <= 1'b1;
                  imem_addr_r   <= '0;
                  fetch_count_r <= 8'd0;
                  done_r        <= 1'b0;
                  busy_r        <= 1'b1;
               end
            end
            S_FETCH: begin
               imem_rd_en_r <= 1'b0;
               if (halt_req) begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= S_WAIT;
               end
            end
            S_WAIT: begin
               // Halting here drops the read data that is arriving this cycle.
               if (halt_req) begin
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  dec_instr_r <= bus.imem_data;
                  dec_pc_r    <= pc_r;
                  dec_valid_r <= 1'b1;
                  state_r     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (xfer_s) begin
                  dec_valid_r   <= 1'b0;
                  fetch_count_r <= count_inc_s;
                  if (stop_s) begin
                     state_r <= S_DONE;
                     done_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r      <= S_FETCH;
                     pc_r         <= next_pc_s;
                     imem_addr_r  <= next_pc_s;
                     imem_rd_en_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r      <= S_IDLE;
               imem_rd_en_r <= 1'b0;
               dec_valid_r  <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboard of expected transfers and
// fetch addresses, checked against a PROG_LEN=4 and a PROG_LEN=32 instance.
module tb_fetch_sequencer;
   localparam int PC_W = 5;

   typedef struct {
      logic [PC_W-1:0] pc;
      logic [31:0]     instr;
      int              cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start4, halt4, busy4, done4;
   logic       start32, halt32, busy32, done32;
   logic [7:0] cnt4, cnt32;
   int         tests = 0;
   int         failures = 0;
   exp_t            sb[$];
   logic [PC_W-1:0] addr_q[$];

   fetch_sequencer_if #(.PC_W(PC_W)) if4 ();
   fetch_sequencer_if #(.PC_W(PC_W)) if32 ();

   fetch_sequencer #(.PC_W(PC_W), .PROG_LEN(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .halt_req(halt4),
      .busy(busy4), .done(done4), .fetch_count(cnt4), .bus(if4.master)
   );

   fetch_sequencer #(.PC_W(PC_W), .PROG_LEN(32)) dut32 (
      .clk(clk), .reset(reset), .start(start32), .halt_req(halt32),
      .busy(busy32), .done(done32), .fetch_count(cnt32), .bus(if32.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
      return 32'hA000_0001 + {27'd0, a};
   endfunction

   // One-cycle synchronous instruction memories.
   always @(posedge clk) begin
      if (if4.imem_rd_en) if4.imem_data <= word_at(if4.imem_addr);
      if (if32.imem_rd_en) if32.imem_data <= word_at(if32.imem_addr);
   end

   task automatic push_exp(input int pc, input int cyc);
      exp_t x;
      x.pc    = PC_W'(pc);
      x.instr = word_at(PC_W'(pc));
      x.cyc   = cyc;
      sb.push_back(x);
      addr_q.push_back(PC_W'(pc));
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      tests++;
      if ({if4.imem_rd_en, if4.imem_addr, if4.dec_valid, if4.dec_instr, if4.dec_pc, busy4, done4, cnt4} !== 54'd0) begin
         failures++;
         $display("FAIL reset_outputs4: got %h, want 0", {if4.imem_rd_en, if4.imem_addr, if4.dec_valid, if4.dec_instr, if4.dec_pc, busy4, done4, cnt4});
      end
      tests++;
      if ({if32.imem_rd_en, if32.imem_addr, if32.dec_valid, if32.dec_instr, if32.dec_pc, busy32, done32, cnt32} !== 54'd0) begin
         failures++;
         $display("FAIL reset_outputs32: got %h, want 0", {if32.imem_rd_en, if32.imem_addr, if32.dec_valid, if32.dec_instr, if32.dec_pc, busy32, done32, cnt32});
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if ({if4.dec_valid, if4.imem_rd_en, busy4, done4} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_quiet: valid/rd/busy/done=%b, want 0000", {if4.dec_valid, if4.imem_rd_en, busy4, done4});
         end
      end
   endtask

   task automatic test_straight_run();
      exp_t x;
      logic [PC_W-1:0] a;
      sb.delete(); addr_q.delete();
      for (int i = 0; i < 4; i++) push_exp(i, 3 * (i + 1));
      if4.dec_ready = 1'b1;
      start4 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start4 = (k == 7);   // start while busy must be ignored
         if (if4.imem_rd_en) begin
            tests++;
            a = (addr_q.size() != 0) ? addr_q.pop_front() : '1;
            if (if4.imem_addr !== a) begin
               failures++;
               $display("FAIL straight_addr: got %0d, want %0d", if4.imem_addr, a);
            end
         end
         if (if4.dec_valid && if4.dec_ready && sb.size() != 0) begin
            x = sb.pop_front();
            tests++;
            if (if4.dec_pc !== x.pc || if4.dec_instr !== x.instr || k != x.cyc) begin
               failures++;
               $display("FAIL straight_xfer: got pc=%0d instr=%h cyc=%0d, want pc=%0d instr=%h cyc=%0d", if4.dec_pc, if4.dec_instr, k, x.pc, x.instr, x.cyc);
            end
            if (sb.size() == 0) break;
         end
      end
      start4 = 1'b0;
      @(negedge clk);
      tests++;
      if (sb.size() != 0 || addr_q.size() != 0 || done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 8'd4 || if4.dec_valid !== 1'b0) begin
         failures++;
         $display("FAIL straight_done: left=%0d/%0d done=%b busy=%b count=%0d valid=%b, want 0/0 1 0 4 0", sb.size(), addr_q.size(), done4, busy4, cnt4, if4.dec_valid);
      end
   endtask

   task automatic test_backpressure();
      exp_t x;
      logic [PC_W-1:0] a;
      int stall = 0;
      sb.delete(); addr_q.delete();
      push_exp(0, 3); push_exp(1, 11); push_exp(2, 14); push_exp(3, 17);
      start4 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (if4.dec_valid && if4.dec_pc == 5'd1 && stall < 5) begin
            if4.dec_ready = 1'b0;
            stall++;
            tests++;
            if (if4.dec_instr !== word_at(5'd1) || if4.imem_rd_en !== 1'b0) begin
               failures++;
               $display("FAIL bp_hold: instr=%h rd_en=%b, want %h 0", if4.dec_instr, if4.imem_rd_en, word_at(5'd1));
            end
         end else begin
            if4.dec_ready = 1'b1;
         end
         if (if4.imem_rd_en) begin
            tests++;
            a = (addr_q.size() != 0) ? addr_q.pop_front() : '1;
            if (if4.imem_addr !== a) begin
               failures++;
               $display("FAIL bp_addr: got %0d, want %0d", if4.imem_addr, a);
            end
         end
         if (if4.dec_valid && if4.dec_ready && sb.size() != 0) begin
            x = sb.pop_front();
            tests++;
            if (if4.dec_pc !== x.pc || if4.dec_instr !== x.instr || k != x.cyc) begin
               failures++;
               $display("FAIL bp_xfer: got pc=%0d instr=%h cyc=%0d, want pc=%0d instr=%h cyc=%0d", if4.dec_pc, if4.dec_instr, k, x.pc, x.instr, x.cyc);
            end
            if (sb.size() == 0) break;
         end
      end
      if4.dec_ready = 1'b1;
      @(negedge clk);
      tests++;
      if (sb.size() != 0 || stall != 5 || done4 !== 1'b1 || cnt4 !== 8'd4) begin
         failures++;
         $display("FAIL bp_done: left=%0d stalls=%0d done=%b count=%0d, want 0 5 1 4", sb.size(), stall, done4, cnt4);
      end
   endtask

   task automatic test_branch();
      exp_t x;
      logic [PC_W-1:0] a;
      logic prev_rd = 1'b0;
      logic wait_br = 1'b0, br2 = 1'b0, br3 = 1'b0;
      int seq[10] = '{0, 1, 2, 0, 1, 2, 3, 1, 2, 3};
      sb.delete(); addr_q.delete();
      for (int i = 0; i < 10; i++) push_exp(seq[i], 3 * (i + 1));
      start4 = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         start4 = 1'b0;
         if4.branch_valid = 1'b0;
         if (prev_rd && !wait_br) begin
            if4.branch_valid = 1'b1; if4.branch_target = 5'd3; wait_br = 1'b1;
         end else if (if4.dec_valid && if4.dec_pc == 5'd2 && !br2) begin
            if4.branch_valid = 1'b1; if4.branch_target = 5'd0; br2 = 1'b1;
         end else if (if4.dec_valid && if4.dec_pc == 5'd3 && !br3) begin
            if4.branch_valid = 1'b1; if4.branch_target = 5'd1; br3 = 1'b1;
         end
         prev_rd = if4.imem_rd_en;
         if (if4.imem_rd_en) begin
            tests++;
            a = (addr_q.size() != 0) ? addr_q.pop_front() : '1;
            if (if4.imem_addr !== a) begin
               failures++;
               $display("FAIL branch_addr: got %0d, want %0d", if4.imem_addr, a);
            end
         end
         if (if4.dec_valid && if4.dec_ready && sb.size() != 0) begin
            x = sb.pop_front();
            tests++;
            if (if4.dec_pc !== x.pc || if4.dec_instr !== x.instr || k != x.cyc) begin
               failures++;
               $display("FAIL branch_xfer: got pc=%0d instr=%h cyc=%0d, want pc=%0d instr=%h cyc=%0d", if4.dec_pc, if4.dec_instr, k, x.pc, x.instr, x.cyc);
            end
            if (sb.size() == 0) break;
         end
      end
      if4.branch_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (sb.size() != 0 || done4 !== 1'b1 || cnt4 !== 8'd10) begin
         failures++;
         $display("FAIL branch_done: left=%0d done=%b count=%0d, want 0 1 10", sb.size(), done4, cnt4);
      end
   endtask

   task automatic test_halt_wait();
      exp_t x;
      logic prev_rd = 1'b0;
      logic [PC_W-1:0] prev_addr = '0;
      sb.delete();
      push_exp(0, 3);
      start4 = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         start4 = 1'b0;
         halt4 = prev_rd && (prev_addr == 5'd1);
         prev_rd = if4.imem_rd_en;
         prev_addr = if4.imem_addr;
         if (if4.dec_valid && if4.dec_ready && sb.size() != 0) begin
            x = sb.pop_front();
            tests++;
            if (if4.dec_pc !== x.pc || k != x.cyc) begin
               failures++;
               $display("FAIL halt_wait_xfer: got pc=%0d cyc=%0d, want pc=%0d cyc=%0d", if4.dec_pc, k, x.pc, x.cyc);
            end
         end
         if (k == 6) begin
            tests++;
            if (done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 8'd1) begin
               failures++;
               $display("FAIL halt_wait_done: done=%b busy=%b count=%0d, want 1 0 1", done4, busy4, cnt4);
            end
         end
         if (k >= 5) begin
            tests++;
            if (if4.dec_valid !== 1'b0) begin
               failures++;
               $display("FAIL halt_wait_novalid: dec_valid=%b at cycle %0d, want 0", if4.dec_valid, k);
            end
         end
      end
      halt4 = 1'b0;
   endtask

   task automatic test_halt_issue();
      int seen = 0;
      logic xfered = 1'b0;
      start4 = 1'b1;
      for (int k = 1; k <= 12 && !xfered; k++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (if4.dec_valid && seen == 0) begin
            seen = k; halt4 = 1'b1; if4.dec_ready = 1'b0;
         end else if (if4.dec_valid) begin
            halt4 = 1'b1; if4.dec_ready = 1'b1;
            if4.branch_valid = 1'b1; if4.branch_target = 5'd2;
            tests++;
            if (if4.dec_pc !== 5'd0 || k != 4) begin
               failures++;
               $display("FAIL halt_issue_xfer: got pc=%0d cyc=%0d, want pc=0 cyc=4", if4.dec_pc, k);
            end
            xfered = 1'b1;
         end
      end
      @(negedge clk);
      halt4 = 1'b0; if4.branch_valid = 1'b0; if4.dec_ready = 1'b1;
      tests++;
      if (!xfered || done4 !== 1'b1 || busy4 !== 1'b0 || cnt4 !== 8'd1 || if4.imem_rd_en !== 1'b0 || if4.dec_valid !== 1'b0) begin
         failures++;
         $display("FAIL halt_issue_done: xfer=%b done=%b busy=%b count=%0d rd=%b valid=%b, want 1 1 0 1 0 0", xfered, done4, busy4, cnt4, if4.imem_rd_en, if4.dec_valid);
      end
   endtask

   task automatic test_reset_mid_run();
      int k = 0;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      while (!if4.dec_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      reset = 1'b1;
      #1;
      tests++;
      if (k >= 10 || {if4.imem_rd_en, if4.imem_addr, if4.dec_valid, if4.dec_instr, if4.dec_pc, busy4, done4, cnt4} !== 54'd0) begin
         failures++;
         $display("FAIL reset_mid_run: waited=%0d outputs=%h, want all zero", k, {if4.imem_rd_en, if4.imem_addr, if4.dec_valid, if4.dec_instr, if4.dec_pc, busy4, done4, cnt4});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         tests++;
         if ({if4.dec_valid, if4.imem_rd_en, busy4, done4} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_after: valid/rd/busy/done=%b, want 0000", {if4.dec_valid, if4.imem_rd_en, busy4, done4});
         end
      end
   endtask

   task automatic test_saturation_restart();
      exp_t x;
      logic [PC_W-1:0] a;
      int n = 0;
      int exp_cnt;
      sb.delete(); addr_q.delete();
      for (int i = 0; i < 300; i++) push_exp(i % 32, 3 * (i + 1));
      addr_q.push_back(5'd12);
      if32.dec_ready = 1'b1;
      start32 = 1'b1;
      for (int k = 1; k <= 1000 && n < 300; k++) begin
         @(negedge clk);
         start32 = 1'b0;
         if32.branch_valid = if32.dec_valid && (if32.dec_pc == 5'd31);
         if32.branch_target = 5'd0;
         exp_cnt = (n > 255) ? 255 : n;
         tests++;
         if (cnt32 !== exp_cnt[7:0]) begin
            failures++;
            $display("FAIL sat_count: got %0d, want %0d after %0d transfers", cnt32, exp_cnt, n);
         end
         if (if32.imem_rd_en) begin
            tests++;
            a = (addr_q.size() != 0) ? addr_q.pop_front() : '1;
            if (if32.imem_addr !== a) begin
               failures++;
               $display("FAIL sat_addr: got %0d, want %0d", if32.imem_addr, a);
            end
         end
         if (if32.dec_valid && if32.dec_ready && sb.size() != 0) begin
            x = sb.pop_front();
            n++;
            tests++;
            if (if32.dec_pc !== x.pc || if32.dec_instr !== x.instr || k != x.cyc) begin
               failures++;
               $display("FAIL sat_xfer: got pc=%0d instr=%h cyc=%0d, want pc=%0d instr=%h cyc=%0d", if32.dec_pc, if32.dec_instr, k, x.pc, x.instr, x.cyc);
            end
         end
      end
      if32.branch_valid = 1'b0;
      @(negedge clk);
      halt32 = 1'b1;
      tests++;
      if (n != 300 || if32.imem_rd_en !== 1'b1 || if32.imem_addr !== addr_q[0]) begin
         failures++;
         $display("FAIL sat_last_fetch: transfers=%0d rd=%b addr=%0d, want 300 1 12", n, if32.imem_rd_en, if32.imem_addr);
      end
      @(negedge clk);
      halt32 = 1'b0;
      tests++;
      if (done32 !== 1'b1 || busy32 !== 1'b0 || cnt32 !== 8'd255) begin
         failures++;
         $display("FAIL sat_done: done=%b busy=%b count=%0d, want 1 0 255", done32, busy32, cnt32);
      end
      start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      tests++;
      if (done32 !== 1'b0 || cnt32 !== 8'd0 || busy32 !== 1'b1 || if32.imem_rd_en !== 1'b1 || if32.imem_addr !== 5'd0) begin
         failures++;
         $display("FAIL restart: done=%b count=%0d busy=%b rd=%b addr=%0d, want 0 0 1 1 0", done32, cnt32, busy32, if32.imem_rd_en, if32.imem_addr);
      end
      repeat (2) @(negedge clk);
      tests++;
      if (if32.dec_valid !== 1'b1 || if32.dec_pc !== 5'd0 || if32.dec_instr !== word_at(5'd0)) begin
         failures++;
         $display("FAIL restart_first: valid=%b pc=%0d instr=%h, want 1 0 %h", if32.dec_valid, if32.dec_pc, if32.dec_instr, word_at(5'd0));
      end
   endtask

   initial begin
      reset = 1'b1;
      start4 = 1'b0; halt4 = 1'b0; start32 = 1'b0; halt32 = 1'b0;
      if4.dec_ready = 1'b1; if4.branch_valid = 1'b0; if4.branch_target = 5'd0;
      if32.dec_ready = 1'b1; if32.branch_valid = 1'b0; if32.branch_target = 5'd0;
      test_reset();
      test_straight_run();
      test_backpressure();
      test_branch();
      test_halt_wait();
      test_halt_issue();
      test_reset_mid_run();
      test_saturation_restart();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end
endmodule
